// File: rtl/nonce_sequencer.sv
// Nonce search dispatcher driving one sha256 core per nonce.
// Optional `NONCE_BSWAP_EN: serialize nonce little-endian into the block.
module nonce_sequencer #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic [639:0] core_block,
    output logic         core_rst_n,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         error,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  hash_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]   state;
    logic [607:0] header_q;
    logic [31:0]  end_q;
    logic [255:0] target_q;
    logic [31:0]  nonce_q;
    logic [31:0]  cnt;
    logic [255:0] hash_q;
    logic [31:0]  nonce_field;

`ifdef NONCE_BSWAP_EN
    assign nonce_field = {nonce_q[7:0], nonce_q[15:8],
                          nonce_q[23:16], nonce_q[31:24]};
`else
    assign nonce_field = nonce_q;
`endif

    assign core_block = {header_q, nonce_field};
    assign core_rst_n = (state == S_RUN);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            header_q    <= '0;
            end_q       <= '0;
            target_q    <= '0;
            nonce_q     <= '0;
            cnt         <= '0;
            hash_q      <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            error       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
        end else begin
            done <= 1'b0;
            // abort overrides any same-cycle core_done or CHECK hit
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                cnt   <= '0;
                done  <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            header_q   <= header;
                            end_q      <= nonce_end;
                            target_q   <= target;
                            nonce_q    <= nonce_start;
                            found      <= 1'b0;
                            error      <= 1'b0;
                            hash_count <= '0;
                            cnt        <= '0;
                            state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (cnt == 32'(RST_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= S_RUN;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_RUN: begin
                        if (core_done) begin
                            hash_q <= core_hash;
                            state  <= S_CHECK;
                        end else if (cnt == 32'(TIMEOUT - 1)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_CHECK: begin
                        cnt <= '0;
                        if (hash_count != 32'hFFFF_FFFF)
                            hash_count <= hash_count + 32'd1;
                        if (hash_q <= target_q) begin
                            found       <= 1'b1;
                            found_nonce <= nonce_q;
                            found_hash  <= hash_q;
                            done        <= 1'b1;
                            state       <= S_IDLE;
                        end else if (nonce_q == end_q) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                            state   <= S_LOAD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Scoreboard bench for nonce_sequencer using a fixed-latency stub core.
// Expected block fields and search results are queued, a monitor checks them.
module tb_nonce_sequencer;

    localparam logic [607:0] GEN_HDR = {
        32'h01000000,
        256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49,
        32'hffff001d};
    localparam logic [255:0] GEN_HASH =
        256'haf42031e805ff493a07341e2f74ff58149d22ab9ba19f61343e2c86c71c5d66d;
    localparam logic [255:0] ONES  = {256{1'b1}};
    localparam logic [255:0] SMALL = 256'h1234_5678;

    typedef struct {
        bit           f;
        bit           e;
        logic [31:0]  n;
        logic [255:0] h;
        logic [31:0]  c;
        int           lat;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [607:0] header = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic [639:0] core_block;
    logic         core_rst_n;
    logic [255:0] core_hash;
    logic         core_done;
    logic         busy, done, found, error;
    logic [31:0]  found_nonce, hash_count;
    logic [255:0] found_hash;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int run_cyc = 0;
    int run_entries = 0;
    logic [607:0] hdr_exp = '0;
    logic [31:0]  exp_blk[$];
    res_t         exp_res[$];

    logic         hang = 1'b0;
    logic [255:0] stub_hash = '0;
    logic [7:0]   stub_cnt;
    logic         prev_rn = 1'b0;

    nonce_sequencer #(.RST_CYCLES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header(header), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .target(target),
        .core_block(core_block), .core_rst_n(core_rst_n),
        .core_hash(core_hash), .core_done(core_done),
        .busy(busy), .done(done), .found(found), .error(error),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .hash_count(hash_count));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stub core: done four cycles after release, held until reset
    assign core_hash = stub_hash;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            stub_cnt  <= '0;
            core_done <= 1'b0;
        end else if (!hang && stub_cnt == 8'd3) begin
            core_done <= 1'b1;
        end else begin
            stub_cnt <= stub_cnt + 8'd1;
        end
    end

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
        return n;
`endif
    endfunction

    task automatic push_res(input bit f, input bit e, input logic [31:0] n,
                            input logic [255:0] h, input logic [31:0] c,
                            input int lat);
        res_t r;
        r.f = f; r.e = e; r.n = n; r.h = h; r.c = c; r.lat = lat;
        exp_res.push_back(r);
    endtask

    task automatic go(input logic [607:0] h, input logic [31:0] s,
                      input logic [31:0] e, input logic [255:0] t);
        @(posedge clk); #1;
        header = h; nonce_start = s; nonce_end = e; target = t;
        hdr_exp = h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 256'(busy), 256'(1));
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({nm, "_done_seen"}, 256'(seen), 256'(1));
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_busy"}, 256'(busy), 256'(0));
        check({nm, "_done"}, 256'(done), 256'(0));
        check({nm, "_found"}, 256'(found), 256'(0));
        check({nm, "_error"}, 256'(error), 256'(0));
        check({nm, "_rst_n"}, 256'(core_rst_n), 256'(0));
        check({nm, "_block"}, 256'(core_block != '0), 256'(0));
        check({nm, "_fnonce"}, 256'(found_nonce), 256'(0));
        check({nm, "_fhash"}, found_hash, 256'(0));
        check({nm, "_count"}, 256'(hash_count), 256'(0));
    endtask

    // monitor: block issued at each RUN entry, result at each done pulse
    always @(negedge clk) begin
        if (rst) begin
            prev_rn <= 1'b0;
        end else begin
            prev_rn <= core_rst_n;
            if (core_rst_n && !prev_rn) begin
                run_entries <= run_entries + 1;
                run_cyc <= cyc;
                if (exp_blk.size() == 0) begin
                    check("unexpected_block", 256'(core_block[31:0]), 256'(0));
                end else begin
                    check("block_nonce", 256'(core_block[31:0]),
                          256'(exp_blk.pop_front()));
                    check("block_header", 256'(core_block[639:32] != hdr_exp),
                          256'(0));
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_done", 256'(done), 256'(0));
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("res_found", 256'(found), 256'(r.f));
                    check("res_error", 256'(error), 256'(r.e));
                    check("res_count", 256'(hash_count), 256'(r.c));
                    check("res_busy", 256'(busy), 256'(0));
                    check("res_rst_n", 256'(core_rst_n), 256'(0));
                    if (r.f) begin
                        check("res_nonce", 256'(found_nonce), 256'(r.n));
                        check("res_hash", found_hash, r.h);
                    end
                    if (r.lat > 0)
                        check("res_latency", 256'(cyc - run_cyc), 256'(r.lat));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("after_reset");

        // genesis nonce, all-ones target
        stub_hash = GEN_HASH;
        exp_blk.push_back(bsw(32'h7C2BAC1D));
        push_res(1, 0, 32'h7C2BAC1D, GEN_HASH, 32'd1, 0);
        go(GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC1D, ONES);
        wait_done("genesis");

        // zero target over four nonces
        for (int i = 0; i < 4; i++)
            exp_blk.push_back(bsw(32'h7C2BAC1D + 32'(i)));
        push_res(0, 0, 32'h0, '0, 32'd4, 0);
        go(GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC20, '0);
        wait_done("miss4");

        // wrapping range
        stub_hash = ONES;
        exp_blk.push_back(bsw(32'hFFFFFFFE));
        exp_blk.push_back(bsw(32'hFFFFFFFF));
        exp_blk.push_back(bsw(32'h00000000));
        exp_blk.push_back(bsw(32'h00000001));
        push_res(0, 0, 32'h0, '0, 32'd4, 0);
        go({19{32'hA5A5_0F0F}}, 32'hFFFFFFFE, 32'h00000001, '0);
        wait_done("wrap");

        // hash equal to target is a hit, one below is a miss
        stub_hash = SMALL;
        exp_blk.push_back(bsw(32'd5));
        push_res(1, 0, 32'd5, SMALL, 32'd1, 0);
        go({19{32'h1111_2222}}, 32'd5, 32'd5, SMALL);
        wait_done("eq_target");
        exp_blk.push_back(bsw(32'd5));
        push_res(0, 0, 32'h0, '0, 32'd1, 0);
        go({19{32'h1111_2222}}, 32'd5, 32'd5, SMALL - 256'd1);
        wait_done("below_target");

        // abort during second RUN, restart right after
        begin
            int base;
            bit hit = 1'b0;
            stub_hash = ONES;
            base = run_entries;
            exp_blk.push_back(bsw(32'd10));
            exp_blk.push_back(bsw(32'd11));
            push_res(0, 0, 32'h0, '0, 32'd1, 0);
            go({19{32'h3333_4444}}, 32'd10, 32'd20, '0);
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (run_entries == base + 2) hit = 1'b1;
            end
            check("abort_reach_run2", 256'(hit), 256'(1));
            @(posedge clk); #1;
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            exp_blk.push_back(bsw(32'd30));
            push_res(1, 0, 32'd30, ONES, 32'd1, 0);
            header = {19{32'h5555_6666}}; hdr_exp = header;
            nonce_start = 32'd30; nonce_end = 32'd30; target = ONES;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("restart_busy", 256'(busy), 256'(1));
            wait_done("restart");
        end

        // hung core times out; start while busy ignored
        hang = 1'b1;
        exp_blk.push_back(bsw(32'd40));
        push_res(0, 1, 32'h0, '0, 32'd0, 16);
        go({19{32'h7777_8888}}, 32'd40, 32'd50, ONES);
        repeat (3) @(posedge clk);
        #1;
        nonce_start = 32'd99; nonce_end = 32'd99;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("timeout");
        hang = 1'b0;
        check("error_sticky", 256'(error), 256'(1));

        // reset in the middle of LOAD
        exp_blk.push_back(bsw(32'd60));
        push_res(1, 0, 32'd60, ONES, 32'd1, 0);
        go({19{32'h9999_AAAA}}, 32'd60, 32'd60, ONES);
        wait_done("pre_rst");
        go({19{32'h9999_AAAA}}, 32'd70, 32'd80, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("mid_load_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("post_mid_rst");
        repeat (20) @(posedge clk);

        check("blk_queue_empty", 256'(exp_blk.size()), 256'(0));
        check("res_queue_empty", 256'(exp_res.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
